// File: rtl/fifo_gen_packer_pkg.sv
// Shared helpers for the fifo_gen family: lane-index width for packers/unpackers.
package fifo_gen_packer_pkg;

   // A lane counter needs at least one bit even when a word holds a single beat.
   function automatic int lane_idx_width(input int ratio_idx);
      return (ratio_idx > 0) ? ratio_idx : 1;
   endfunction

endpackage

// File: rtl/fifo_gen_packer.sv
// Width up-converter in front of fifo_gen: packs 2**RATIO_IDX narrow beats into one
// wide word, with early flush on in_last and a one-entry output slot.
module fifo_gen_packer
   import fifo_gen_packer_pkg::*;
#(
   parameter int IN_SIZE   = 4,
   parameter int RATIO_IDX = 1
) (
   input  logic                              clk,
   input  logic                              rst_n,
   input  logic                              in_val,
   output logic                              in_rdy,
   input  logic [IN_SIZE-1:0]                in_data,
   input  logic                              in_last,
   output logic                              out_val,
   input  logic                              out_rdy,
   output logic [(IN_SIZE<<RATIO_IDX)-1:0]   out_data,
   output logic [RATIO_IDX:0]                out_cnt
);

   localparam int RATIO    = 1 << RATIO_IDX;
   localparam int OUT_SIZE = IN_SIZE * RATIO;
   localparam int CNT_W    = lane_idx_width(RATIO_IDX);
   localparam int OCNT_W   = RATIO_IDX + 1;
   localparam logic [CNT_W-1:0] LAST_LANE = CNT_W'(RATIO - 1);

   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [OUT_SIZE-1:0] acc_q, acc_d;
   logic                out_val_q, out_val_d;
   logic [OUT_SIZE-1:0] out_data_q, out_data_d;
   logic [OCNT_W-1:0]   out_cnt_q, out_cnt_d;

   logic                last_lane;
   logic                accept;
   logic                complete;
   logic                pop;
   logic [OUT_SIZE-1:0] merged;

   assign last_lane = (cnt_q == LAST_LANE);
   // Stall only when this beat would complete a word and the slot cannot drain.
   assign in_rdy    = !out_val_q || out_rdy || (!last_lane && !in_last);
   assign accept    = in_val && in_rdy;
   assign complete  = accept && (last_lane || in_last);
   assign pop       = out_val_q && out_rdy;

   // Accumulator with the incoming beat dropped into the current lane; lanes above
   // cnt are already zero because acc is cleared on every completed word.
   generate
      for (genvar gi = 0; gi < RATIO; gi++) begin : g_lane
         assign merged[gi*IN_SIZE +: IN_SIZE] =
            (cnt_q == CNT_W'(gi)) ? in_data : acc_q[gi*IN_SIZE +: IN_SIZE];
      end
   endgenerate

   always_comb begin
      cnt_d      = cnt_q;
      acc_d      = acc_q;
      out_val_d  = out_val_q;
      out_data_d = out_data_q;
      out_cnt_d  = out_cnt_q;
      if (pop) begin
         out_val_d = 1'b0;
      end
      if (complete) begin
         cnt_d      = '0;
         acc_d      = '0;
         out_val_d  = 1'b1;
         out_data_d = merged;
         out_cnt_d  = OCNT_W'(cnt_q) + OCNT_W'(1);
      end else if (accept) begin
         cnt_d = cnt_q + CNT_W'(1);
         acc_d = merged;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q      <= '0;
         acc_q      <= '0;
         out_val_q  <= 1'b0;
         out_data_q <= '0;
         out_cnt_q  <= '0;
      end else begin
         cnt_q      <= cnt_d;
         acc_q      <= acc_d;
         out_val_q  <= out_val_d;
         out_data_q <= out_data_d;
         out_cnt_q  <= out_cnt_d;
      end
   end

   assign out_val  = out_val_q;
   assign out_data = out_data_q;
   assign out_cnt  = out_cnt_q;

endmodule

// File: tb/tb_fifo_gen_packer.sv
// Self-checking bench for fifo_gen_packer (IN_SIZE=4, RATIO_IDX=1): directed vectors,
// randomized traffic against a beat-queue reference model, and a 4-deep FIFO chain.
module tb_fifo_gen_packer;

   localparam int IN_SIZE   = 4;
   localparam int RATIO_IDX = 1;
   localparam int RATIO     = 2;
   localparam int OUT_SIZE  = 8;

   logic                clk = 1'b0;
   logic                rst_n = 1'b0;
   logic                in_val = 1'b0;
   logic                in_rdy;
   logic [IN_SIZE-1:0]  in_data = '0;
   logic                in_last = 1'b0;
   logic                out_val;
   logic                out_rdy = 1'b0;
   logic [OUT_SIZE-1:0] out_data;
   logic [RATIO_IDX:0]  out_cnt;

   int checks = 0;
   int failures = 0;

   fifo_gen_packer #(.IN_SIZE(IN_SIZE), .RATIO_IDX(RATIO_IDX)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_val(in_val), .in_rdy(in_rdy), .in_data(in_data), .in_last(in_last),
      .out_val(out_val), .out_rdy(out_rdy), .out_data(out_data), .out_cnt(out_cnt)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, got timeout required finish");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic       v;
      logic [3:0] d;
      logic       l;
      logic       r;
      logic       e_rdy;
      logic       e_val;
      logic [7:0] e_data;
      logic [1:0] e_cnt;
   } vec_t;

   vec_t vq[$];

   typedef struct {
      logic [7:0] d;
      logic [1:0] c;
   } word_t;

   // Reference model: beats of the word being gathered, and the output slot.
   logic [3:0] m_beats[$];
   word_t      m_slot[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
      end
   endtask

   task automatic add(input logic v, input logic [3:0] d, input logic l, input logic r,
                      input logic e_rdy, input logic e_val, input logic [7:0] e_data,
                      input logic [1:0] e_cnt);
      vec_t x;
      x.v = v; x.d = d; x.l = l; x.r = r;
      x.e_rdy = e_rdy; x.e_val = e_val; x.e_data = e_data; x.e_cnt = e_cnt;
      vq.push_back(x);
   endtask

   task automatic drive(input logic v, input logic [3:0] d, input logic l, input logic r);
      in_val = v; in_data = d; in_last = l; out_rdy = r;
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      drive(1'b0, 4'h0, 1'b0, 1'b0);
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   function automatic word_t pack_beats(input logic [3:0] beats[$]);
      word_t w;
      w.d = '0;
      for (int k = 0; k < beats.size(); k++) w.d = w.d | (8'(beats[k]) << (4 * k));
      w.c = 2'(beats.size());
      return w;
   endfunction

   logic [3:0] beat_v[20];
   logic [7:0] exp_w[10];
   logic [7:0] fifo_q[$];
   logic [7:0] got[$];

   initial begin
      do_reset();

      // Reset state
      @(negedge clk);
      chk("reset_out_val", out_val, 0);
      chk("reset_out_data", out_data, 0);
      chk("reset_out_cnt", out_cnt, 0);
      chk("reset_in_rdy", in_rdy, 1);
      next_cycle();

      // Full word, partial flush, backpressure, streaming
      add(1, 4'h3, 0, 1,  1, 0, 8'h00, 0);
      add(1, 4'hA, 0, 1,  1, 0, 8'h00, 0);
      add(0, 4'h0, 0, 1,  1, 1, 8'hA3, 2);
      add(0, 4'h0, 0, 1,  1, 0, 8'h00, 0);
      add(1, 4'h5, 1, 1,  1, 0, 8'h00, 0);
      add(0, 4'h0, 0, 1,  1, 1, 8'h05, 1);
      add(0, 4'h0, 0, 1,  1, 0, 8'h00, 0);
      add(1, 4'h1, 0, 0,  1, 0, 8'h00, 0);
      add(1, 4'h2, 0, 0,  1, 0, 8'h00, 0);
      add(1, 4'h4, 0, 0,  1, 1, 8'h21, 2);
      add(1, 4'h6, 0, 0,  0, 1, 8'h21, 2);
      add(1, 4'h6, 0, 0,  0, 1, 8'h21, 2);
      add(1, 4'h6, 0, 1,  1, 1, 8'h21, 2);
      add(0, 4'h0, 0, 1,  1, 1, 8'h64, 2);
      add(0, 4'h0, 0, 1,  1, 0, 8'h00, 0);
      for (int i = 0; i < 8; i++) begin
         logic [7:0] w;
         w = (i % 2 == 0 && i > 0) ? {4'(i - 1), 4'(i - 2)} : 8'h00;
         add(1, 4'(i), 0, 1,  1, (i % 2 == 0 && i > 0), w, (i % 2 == 0 && i > 0) ? 2'd2 : 2'd0);
      end
      add(0, 4'h0, 0, 1,  1, 1, 8'h76, 2);
      add(0, 4'h0, 0, 1,  1, 0, 8'h00, 0);

      for (int i = 0; i < vq.size(); i++) begin
         drive(vq[i].v, vq[i].d, vq[i].l, vq[i].r);
         @(negedge clk);
         $display("vec %0d: in_val=%0b in_data=%0h in_last=%0b out_rdy=%0b -> in_rdy=%0b out_val=%0b out_data=%0h out_cnt=%0d",
                  i, in_val, in_data, in_last, out_rdy, in_rdy, out_val, out_data, out_cnt);
         chk($sformatf("vec%0d_in_rdy", i), in_rdy, vq[i].e_rdy);
         chk($sformatf("vec%0d_out_val", i), out_val, vq[i].e_val);
         if (vq[i].e_val) begin
            chk($sformatf("vec%0d_out_data", i), out_data, vq[i].e_data);
            chk($sformatf("vec%0d_out_cnt", i), out_cnt, vq[i].e_cnt);
         end
         next_cycle();
      end

      // Reset mid-word with a full slot: both the slot and the partial 0x9 are discarded
      drive(1, 4'hC, 0, 0); next_cycle();
      drive(1, 4'hD, 0, 0); next_cycle();
      drive(1, 4'h9, 0, 0); next_cycle();
      drive(0, 4'h0, 0, 0);
      #2 rst_n = 1'b0;
      #1;
      chk("rst_mid_out_val", out_val, 0);
      chk("rst_mid_out_data", out_data, 0);
      chk("rst_mid_out_cnt", out_cnt, 0);
      chk("rst_mid_in_rdy", in_rdy, 1);
      @(posedge clk);
      #1 rst_n = 1'b1;
      drive(1, 4'h1, 0, 1); next_cycle();
      drive(1, 4'h2, 0, 1); next_cycle();
      drive(0, 4'h0, 0, 1);
      @(negedge clk);
      $display("post-reset word: out_val=%0b out_data=%0h out_cnt=%0d", out_val, out_data, out_cnt);
      chk("rst_after_out_val", out_val, 1);
      chk("rst_after_out_data", out_data, 8'h21);
      chk("rst_after_out_cnt", out_cnt, 2);
      next_cycle();
      @(negedge clk);
      chk("rst_after_drain", out_val, 0);
      next_cycle();

      // Randomized traffic against the reference model
      m_beats.delete();
      m_slot.delete();
      for (int cyc = 0; cyc < 400; cyc++) begin
         logic  e_rdy, pop, acc;
         word_t w;
         drive($urandom_range(0, 9) < 7, 4'($urandom), $urandom_range(0, 3) == 0,
               $urandom_range(0, 9) < 6);
         e_rdy = (m_slot.size() == 0) || out_rdy ||
                 !((m_beats.size() == RATIO - 1) || in_last);
         @(negedge clk);
         chk("rand_in_rdy", in_rdy, e_rdy);
         chk("rand_out_val", out_val, m_slot.size() != 0);
         if (m_slot.size() != 0) begin
            chk("rand_out_data", out_data, m_slot[0].d);
            chk("rand_out_cnt", out_cnt, m_slot[0].c);
         end
         pop = (m_slot.size() != 0) && out_rdy;
         acc = in_val && e_rdy;
         if (pop) begin
            $display("rand cyc %0d: pop word %0h cnt %0d", cyc, m_slot[0].d, m_slot[0].c);
            void'(m_slot.pop_front());
         end
         if (acc) begin
            m_beats.push_back(in_data);
            if (m_beats.size() == RATIO || in_last) begin
               w = pack_beats(m_beats);
               m_slot.push_back(w);
               m_beats.delete();
            end
         end
         next_cycle();
      end

      // Chained with a 4-entry FIFO that is never popped, then drained
      do_reset();
      for (int w = 0; w < 10; w++) begin
         beat_v[2*w]     = 4'($urandom);
         beat_v[2*w + 1] = 4'($urandom);
         exp_w[w] = {beat_v[2*w + 1], beat_v[2*w]};
      end
      begin
         int bi;
         bi = 0;
         for (int cyc = 0; cyc < 40; cyc++) begin
            drive(bi < 20, (bi < 20) ? beat_v[bi] : 4'h0, 0, fifo_q.size() < 4);
            @(negedge clk);
            if (out_val && out_rdy) fifo_q.push_back(out_data);
            if (in_val && in_rdy) bi++;
            next_cycle();
         end
         drive(1, beat_v[bi], 0, fifo_q.size() < 4);
         @(negedge clk);
         $display("chain stall: fifo=%0d slot_val=%0b slot=%0h in_rdy=%0b beats=%0d",
                  fifo_q.size(), out_val, out_data, in_rdy, bi);
         chk("chain_fifo_level", fifo_q.size(), 4);
         chk("chain_slot_val", out_val, 1);
         chk("chain_slot_data", out_data, exp_w[4]);
         chk("chain_in_rdy", in_rdy, 0);
         chk("chain_beats", bi, 11);
         next_cycle();
         for (int cyc = 0; cyc < 200 && got.size() < 10; cyc++) begin
            drive(bi < 20, (bi < 20) ? beat_v[bi] : 4'h0, 0, fifo_q.size() < 4);
            @(negedge clk);
            if (fifo_q.size() != 0) got.push_back(fifo_q.pop_front());
            if (out_val && out_rdy) fifo_q.push_back(out_data);
            if (in_val && in_rdy) bi++;
            next_cycle();
         end
         chk("chain_drain_count", got.size(), 10);
         for (int i = 0; i < got.size() && i < 10; i++) begin
            $display("chain word %0d: %0h", i, got[i]);
            chk($sformatf("chain_word%0d", i), got[i], exp_w[i]);
         end
         drive(0, 4'h0, 0, 1);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
